// File: rtl/arp_ctrl_if.sv
// rtl/arp_ctrl_if.sv - ARP/UDP transmit arbitration signal bundle
interface arp_ctrl_if;
    logic        arp_rx_end;
    logic [15:0] arp_op;
    logic [31:0] rx_pc_ip;
    logic [47:0] rx_pc_mac;
    logic        arp_req_trig;
    logic        udp_tx_req;
    logic        arp_tx_done;
    logic        udp_tx_done;
    logic        arp_tx_start;
    logic        arp_tx_type;
    logic [31:0] tx_dst_ip;
    logic [47:0] tx_dst_mac;
    logic        udp_tx_grant;
    logic [31:0] pc_ip;
    logic [47:0] pc_mac;
    logic        mac_valid;
    logic        tx_err;

    modport master (
        input  arp_rx_end, arp_op, rx_pc_ip, rx_pc_mac, arp_req_trig,
               udp_tx_req, arp_tx_done, udp_tx_done,
        output arp_tx_start, arp_tx_type, tx_dst_ip, tx_dst_mac,
               udp_tx_grant, pc_ip, pc_mac, mac_valid, tx_err
    );

    modport slave (
        output arp_rx_end, arp_op, rx_pc_ip, rx_pc_mac, arp_req_trig,
               udp_tx_req, arp_tx_done, udp_tx_done,
        input  arp_tx_start, arp_tx_type, tx_dst_ip, tx_dst_mac,
               udp_tx_grant, pc_ip, pc_mac, mac_valid, tx_err
    );
endinterface

// File: rtl/arp_ctrl.sv
// rtl/arp_ctrl.sv - ARP reply/request and UDP TX arbiter with peer address learning
module arp_ctrl #(
    parameter int          IFG_CYCLES = 12,
    parameter int          TX_TIMEOUT = 4095,
    parameter logic [31:0] DEF_PC_IP  = 32'hC0A80166
) (
    input  logic      clk,
    input  logic      rst_n,
    arp_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_ARP_TX = 4'b0010,
        ST_UDP_TX = 4'b0100,
        ST_GAP    = 4'b1000
    } state_t;

    localparam logic [11:0] TO_LAST  = 12'(TX_TIMEOUT - 1);
    localparam logic [11:0] IFG_LAST = 12'(IFG_CYCLES - 1);
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

    state_t      state_q, state_d;
    logic        rep_pend_q, rep_pend_d;
    logic        req_pend_q, req_pend_d;
    logic [11:0] tx_cnt_q, tx_cnt_d;
    logic [11:0] gap_cnt_q, gap_cnt_d;
    logic        arp_tx_start_q, arp_tx_start_d;
    logic        arp_tx_type_q, arp_tx_type_d;
    logic [31:0] tx_dst_ip_q, tx_dst_ip_d;
    logic [47:0] tx_dst_mac_q, tx_dst_mac_d;
    logic        udp_tx_grant_q, udp_tx_grant_d;
    logic [31:0] pc_ip_q, pc_ip_d;
    logic [47:0] pc_mac_q, pc_mac_d;
    logic        mac_valid_q, mac_valid_d;
    logic        tx_err_q, tx_err_d;

    logic set_rep;
    logic learn;

    assign set_rep = bus.arp_rx_end && (bus.arp_op == 16'd1);
    assign learn   = bus.arp_rx_end && ((bus.arp_op == 16'd1) || (bus.arp_op == 16'd2));

    always_comb begin
        state_d        = state_q;
        rep_pend_d     = rep_pend_q | set_rep;
        req_pend_d     = req_pend_q | bus.arp_req_trig;
        tx_cnt_d       = tx_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        arp_tx_start_d = 1'b0;
        arp_tx_type_d  = arp_tx_type_q;
        tx_dst_ip_d    = tx_dst_ip_q;
        tx_dst_mac_d   = tx_dst_mac_q;
        udp_tx_grant_d = 1'b0;
        pc_ip_d        = pc_ip_q;
        pc_mac_d       = pc_mac_q;
        mac_valid_d    = mac_valid_q;
        tx_err_d       = 1'b0;

        // Learning is independent of the TX state; tx_dst_* is only sampled on ARP start.
        if (learn) begin
            pc_ip_d     = bus.rx_pc_ip;
            pc_mac_d    = bus.rx_pc_mac;
            mac_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_cnt_d  = '0;
                gap_cnt_d = '0;
                if (rep_pend_q) begin
                    state_d        = ST_ARP_TX;
                    arp_tx_start_d = 1'b1;
                    arp_tx_type_d  = 1'b1;
                    tx_dst_ip_d    = pc_ip_q;
                    tx_dst_mac_d   = pc_mac_q;
                    rep_pend_d     = set_rep;
                end else if (req_pend_q) begin
                    state_d        = ST_ARP_TX;
                    arp_tx_start_d = 1'b1;
                    arp_tx_type_d  = 1'b0;
                    tx_dst_ip_d    = pc_ip_q;
                    tx_dst_mac_d   = BCAST;
                    req_pend_d     = bus.arp_req_trig;
                end else if (bus.udp_tx_req && mac_valid_q) begin
                    state_d        = ST_UDP_TX;
                    udp_tx_grant_d = 1'b1;
                end
            end
            ST_ARP_TX, ST_UDP_TX: begin
                if ((state_q == ST_ARP_TX) ? bus.arp_tx_done : bus.udp_tx_done) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else if (tx_cnt_q == TO_LAST) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    tx_err_d  = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 12'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 12'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rep_pend_q     <= 1'b0;
            req_pend_q     <= 1'b0;
            tx_cnt_q       <= '0;
            gap_cnt_q      <= '0;
            arp_tx_start_q <= 1'b0;
            arp_tx_type_q  <= 1'b0;
            tx_dst_ip_q    <= DEF_PC_IP;
            tx_dst_mac_q   <= BCAST;
            udp_tx_grant_q <= 1'b0;
            pc_ip_q        <= DEF_PC_IP;
            pc_mac_q       <= BCAST;
            mac_valid_q    <= 1'b0;
            tx_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            rep_pend_q     <= rep_pend_d;
            req_pend_q     <= req_pend_d;
            tx_cnt_q       <= tx_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            arp_tx_start_q <= arp_tx_start_d;
            arp_tx_type_q  <= arp_tx_type_d;
            tx_dst_ip_q    <= tx_dst_ip_d;
            tx_dst_mac_q   <= tx_dst_mac_d;
            udp_tx_grant_q <= udp_tx_grant_d;
            pc_ip_q        <= pc_ip_d;
            pc_mac_q       <= pc_mac_d;
            mac_valid_q    <= mac_valid_d;
            tx_err_q       <= tx_err_d;
        end
    end

    assign bus.arp_tx_start = arp_tx_start_q;
    assign bus.arp_tx_type  = arp_tx_type_q;
    assign bus.tx_dst_ip    = tx_dst_ip_q;
    assign bus.tx_dst_mac   = tx_dst_mac_q;
    assign bus.udp_tx_grant = udp_tx_grant_q;
    assign bus.pc_ip        = pc_ip_q;
    assign bus.pc_mac       = pc_mac_q;
    assign bus.mac_valid    = mac_valid_q;
    assign bus.tx_err       = tx_err_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// tb/tb_arp_ctrl.sv - directed self-checking bench for arp_ctrl
module tb_arp_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n;

    arp_ctrl_if bus();

    arp_ctrl #(
        .IFG_CYCLES(12),
        .TX_TIMEOUT(4095),
        .DEF_PC_IP (32'hC0A80166)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sig(input int which, input int max, output int cnt);
        logic hit;
        cnt = 0;
        do begin
            step();
            cnt++;
            case (which)
                0:       hit = bus.arp_tx_start;
                1:       hit = bus.udp_tx_grant;
                default: hit = bus.tx_err;
            endcase
        end while (!hit && cnt < max);
    endtask

    task automatic count_events(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            step();
            if (bus.arp_tx_start || bus.udp_tx_grant || bus.tx_err) cnt++;
        end
    endtask

    task automatic rx(input logic [15:0] op, input logic [31:0] ip, input logic [47:0] mac);
        bus.arp_rx_end = 1'b1;
        bus.arp_op     = op;
        bus.rx_pc_ip   = ip;
        bus.rx_pc_mac  = mac;
        step();
        bus.arp_rx_end = 1'b0;
    endtask

    initial begin
        bus.arp_rx_end   = 1'b0;
        bus.arp_op       = 16'd0;
        bus.rx_pc_ip     = 32'd0;
        bus.rx_pc_mac    = 48'd0;
        bus.arp_req_trig = 1'b0;
        bus.udp_tx_req   = 1'b0;
        bus.arp_tx_done  = 1'b0;
        bus.udp_tx_done  = 1'b0;

        // reset values
        step();
        step();
        chk("rst_pc_ip", bus.pc_ip, 32'hC0A80166);
        chk("rst_pc_mac", bus.pc_mac, 48'hFFFFFFFFFFFF);
        chk("rst_dst_ip", bus.tx_dst_ip, 32'hC0A80166);
        chk("rst_dst_mac", bus.tx_dst_mac, 48'hFFFFFFFFFFFF);
        chk("rst_mac_valid", bus.mac_valid, 1'b0);
        chk("rst_start", bus.arp_tx_start, 1'b0);
        chk("rst_grant", bus.udp_tx_grant, 1'b0);
        chk("rst_type", bus.arp_tx_type, 1'b0);
        chk("rst_err", bus.tx_err, 1'b0);
        rst_n = 1'b1;
        step();

        // UDP request without a learned MAC is never granted
        bus.udp_tx_req = 1'b1;
        count_events(5, n);
        chk("udp_no_mac_grants", n, 0);

        // unknown opcode is ignored
        rx(16'd3, 32'h01020304, 48'h010203040506);
        chk("op3_pc_ip", bus.pc_ip, 32'hC0A80166);
        chk("op3_mac_valid", bus.mac_valid, 1'b0);
        step();
        chk("op3_no_start", bus.arp_tx_start, 1'b0);

        // ARP reply learned, grant follows next IDLE cycle
        rx(16'd2, 32'h0A000001, 48'hAABBCCDDEEFF);
        chk("op2_mac_valid", bus.mac_valid, 1'b1);
        chk("op2_pc_ip", bus.pc_ip, 32'h0A000001);
        chk("op2_pc_mac", bus.pc_mac, 48'hAABBCCDDEEFF);
        chk("op2_no_grant_yet", bus.udp_tx_grant, 1'b0);
        step();
        chk("op2_grant", bus.udp_tx_grant, 1'b1);
        bus.udp_tx_req = 1'b0;
        step();
        chk("grant_one_cycle", bus.udp_tx_grant, 1'b0);

        // ARP request during UDP_TX held until IFG after udp_tx_done; stray arp_tx_done ignored
        rx(16'd1, 32'hC0A80199, 48'h00AABBCCDDEE);
        chk("udp_pc_ip_update", bus.pc_ip, 32'hC0A80199);
        chk("udp_no_start", bus.arp_tx_start, 1'b0);
        bus.arp_tx_done = 1'b1;
        step();
        bus.arp_tx_done = 1'b0;
        repeat (3) step();
        bus.udp_tx_done = 1'b1;
        step();
        bus.udp_tx_done = 1'b0;
        wait_sig(0, 40, n);
        chk("held_reply_latency", n, 13);
        chk("held_reply_type", bus.arp_tx_type, 1'b1);
        chk("held_reply_dst_ip", bus.tx_dst_ip, 32'hC0A80199);
        chk("held_reply_dst_mac", bus.tx_dst_mac, 48'h00AABBCCDDEE);
        rx(16'd2, 32'h0A0A0A0A, 48'h010203040506);
        chk("arp_tx_pc_ip", bus.pc_ip, 32'h0A0A0A0A);
        chk("dst_ip_frozen", bus.tx_dst_ip, 32'hC0A80199);
        chk("dst_mac_frozen", bus.tx_dst_mac, 48'h00AABBCCDDEE);
        bus.arp_tx_done = 1'b1;
        step();
        bus.arp_tx_done = 1'b0;
        repeat (14) step();

        // ARP request rx in IDLE -> reply start two cycles later
        rx(16'd1, 32'hC0A80166, 48'h001122334455);
        chk("rep_start_k", bus.arp_tx_start, 1'b0);
        chk("rep_mac_valid", bus.mac_valid, 1'b1);
        step();
        chk("rep_start_k1", bus.arp_tx_start, 1'b1);
        chk("rep_type", bus.arp_tx_type, 1'b1);
        chk("rep_dst_ip", bus.tx_dst_ip, 32'hC0A80166);
        chk("rep_dst_mac", bus.tx_dst_mac, 48'h001122334455);
        step();
        chk("rep_start_pulse", bus.arp_tx_start, 1'b0);
        bus.arp_tx_done = 1'b1;
        step();
        bus.arp_tx_done = 1'b0;
        repeat (14) step();

        // priority: reply, then request, then UDP; repeated triggers collapse
        rx(16'd1, 32'h11223344, 48'h665544332211);
        bus.arp_req_trig = 1'b1;
        bus.udp_tx_req   = 1'b1;
        step();
        bus.arp_req_trig = 1'b0;
        chk("prio_reply_start", bus.arp_tx_start, 1'b1);
        chk("prio_reply_type", bus.arp_tx_type, 1'b1);
        step();
        bus.arp_req_trig = 1'b1;
        step();
        bus.arp_req_trig = 1'b0;
        step();
        bus.arp_tx_done = 1'b1;
        step();
        bus.arp_tx_done = 1'b0;
        wait_sig(0, 40, n);
        chk("prio_req_latency", n, 13);
        chk("prio_req_type", bus.arp_tx_type, 1'b0);
        chk("prio_req_dst_ip", bus.tx_dst_ip, 32'h11223344);
        chk("prio_req_dst_mac", bus.tx_dst_mac, 48'hFFFFFFFFFFFF);
        bus.arp_tx_done = 1'b1;
        step();
        bus.arp_tx_done = 1'b0;
        wait_sig(1, 40, n);
        chk("prio_udp_latency", n, 13);
        bus.udp_tx_req = 1'b0;
        step();
        bus.udp_tx_done = 1'b1;
        step();
        bus.udp_tx_done = 1'b0;
        count_events(30, n);
        chk("trig_collapse", n, 0);

        // timeout abort, GAP length, no retry
        bus.arp_req_trig = 1'b1;
        step();
        bus.arp_req_trig = 1'b0;
        wait_sig(0, 5, n);
        chk("to_start", n, 1);
        wait_sig(2, 5000, n);
        chk("to_err_latency", n, 4095);
        bus.arp_req_trig = 1'b1;
        step();
        bus.arp_req_trig = 1'b0;
        chk("to_err_pulse", bus.tx_err, 1'b0);
        wait_sig(0, 40, n);
        chk("to_gap_then_req", n, 12);
        chk("to_req_type", bus.arp_tx_type, 1'b0);

        // reset during ARP_TX: outputs back to reset values, pendings lost, late done ignored
        step();
        bus.arp_req_trig = 1'b1;
        step();
        bus.arp_req_trig = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid_rst_start", bus.arp_tx_start, 1'b0);
        chk("mid_rst_err", bus.tx_err, 1'b0);
        chk("mid_rst_mac_valid", bus.mac_valid, 1'b0);
        chk("mid_rst_type", bus.arp_tx_type, 1'b0);
        chk("mid_rst_pc_ip", bus.pc_ip, 32'hC0A80166);
        chk("mid_rst_dst_mac", bus.tx_dst_mac, 48'hFFFFFFFFFFFF);
        rst_n = 1'b1;
        bus.arp_tx_done = 1'b1;
        step();
        bus.arp_tx_done = 1'b0;
        count_events(40, n);
        chk("mid_rst_quiet", n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
